// File: rtl/tx_arbiter_pkg.sv
// Shared TX command encodings and reply-tracker entry layout for tx_arbiter.
// Imported by the interface, the reply FIFO and the arbiter top.
package tx_arbiter_pkg;

    localparam int TX_CMD_BITS = 4;

    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 4'h1;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h5;

    // Tracker entry: bit 1 = reply expected, bit 0 = route reply to scheduler
    localparam int ENTRY_BITS  = 2;
    localparam int ENTRY_REPLY = 1;
    localparam int ENTRY_TO_SC = 0;

    typedef struct packed {
        logic reply;
        logic to_sc;
    } reply_entry_t;

    function automatic reply_entry_t make_entry(
        input logic grant_sc,
        input logic reply_wanted,
        input logic write_pc
    );
        reply_entry_t e;
        e = '0;
        if (!grant_sc) begin
            e.reply = 1'b1;
            e.to_sc = 1'b0;
        end else if (reply_wanted) begin
            e.reply = 1'b1;
            e.to_sc = !write_pc;
        end
        return e;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Request, memory-interface and status bundle for tx_arbiter.
// master = requester/memory side (testbench), slave = the arbiter.
interface tx_arbiter_if
    import tx_arbiter_pkg::*;
#(
    parameter int IO_BITS  = 2,
    parameter int CMD_BITS = TX_CMD_BITS
);

    logic                pf_cmd_valid;
    logic [CMD_BITS-1:0] pf_cmd;
    logic [IO_BITS-1:0]  pf_data;

    logic                sc_cmd_valid;
    logic [CMD_BITS-1:0] sc_cmd;
    logic [IO_BITS-1:0]  sc_data;
    logic                sc_reserve;
    logic                sc_reply_wanted;

    logic                block_prefetch;
    logic                write_pc;

    logic                mi_cmd_valid;
    logic [CMD_BITS-1:0] mi_cmd;
    logic [IO_BITS-1:0]  mi_data;
    logic                mi_cmd_started;
    logic                mi_tx_active;
    logic                mi_rx_done;

    logic                grant_sc;
    logic                pf_idle;
    logic                rx_to_sc;
    logic                rx_to_pf;
    logic                full;
    logic                empty;

    modport master (
        output pf_cmd_valid, pf_cmd, pf_data,
        output sc_cmd_valid, sc_cmd, sc_data,
        output sc_reserve, sc_reply_wanted,
        output block_prefetch, write_pc,
        output mi_cmd_started, mi_tx_active, mi_rx_done,
        input  mi_cmd_valid, mi_cmd, mi_data,
        input  grant_sc, pf_idle, rx_to_sc, rx_to_pf,
        input  full, empty
    );

    modport slave (
        input  pf_cmd_valid, pf_cmd, pf_data,
        input  sc_cmd_valid, sc_cmd, sc_data,
        input  sc_reserve, sc_reply_wanted,
        input  block_prefetch, write_pc,
        input  mi_cmd_started, mi_tx_active, mi_rx_done,
        output mi_cmd_valid, mi_cmd, mi_data,
        output grant_sc, pf_idle, rx_to_sc, rx_to_pf,
        output full, empty
    );

endinterface

// File: rtl/tx_arbiter_reply_fifo.sv
// reply_fifo: circular FIFO tracking reads that still await a reply.
// Pops on empty are ignored and pushes on full never overwrite.
module reply_fifo #(
    parameter int BITS  = 2,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            add,
    input  logic            remove,
    input  logic [BITS-1:0] new_entry,
    output logic [BITS-1:0] last_entry,
    output logic            empty,
    output logic            full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BITS-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign last_entry = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push on full is legal then
    assign do_pop  = remove & !empty;
    assign do_push = add & (!full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// TX channel arbiter between prefetcher and scheduler, plus reply routing.
// Optional round-robin fairness via macro TX_ARB_ROUND_ROBIN_EN.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int IO_BITS         = 2,
    parameter int CMD_BITS        = TX_CMD_BITS,
    parameter int MAX_OUTSTANDING = 3
) (
    input logic         clk,
    input logic         reset,
    tx_arbiter_if.slave bus
);

    logic                sc_want;
    logic                arb_grant;
    logic                grant;
    logic                grant_q, grant_d;
    logic                valid_sel;
    logic [CMD_BITS-1:0] cmd_sel;
    logic [IO_BITS-1:0]  data_sel;
    logic                is_read;
    logic                push;
    reply_entry_t        new_e;
    logic [ENTRY_BITS-1:0] last_e;
    logic                trk_full;
    logic                trk_empty;

    assign sc_want = bus.sc_cmd_valid | bus.sc_reserve | bus.block_prefetch;

`ifdef TX_ARB_ROUND_ROBIN_EN
    logic last_sc_q, last_sc_d;
    logic contested;

    // Only a plain two-way request race is subject to fairness
    assign contested = bus.pf_cmd_valid & bus.sc_cmd_valid
                     & !bus.sc_reserve & !bus.block_prefetch;
    assign arb_grant = contested ? !last_sc_q : sc_want;
    assign last_sc_d = bus.mi_cmd_started ? grant : last_sc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_sc_q <= 1'b0;
        end else begin
            last_sc_q <= last_sc_d;
        end
    end
`else
    assign arb_grant = sc_want;
`endif

    // Ownership is frozen for the duration of a transfer
    assign grant   = bus.mi_tx_active ? grant_q : arb_grant;
    assign grant_d = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign valid_sel = grant ? bus.sc_cmd_valid : bus.pf_cmd_valid;
    assign cmd_sel   = grant ? bus.sc_cmd       : bus.pf_cmd;
    assign data_sel  = grant ? bus.sc_data      : bus.pf_data;
    assign is_read   = (cmd_sel == CMD_BITS'(TX_HEADER_READ_16));

    assign bus.mi_cmd       = cmd_sel;
    assign bus.mi_data      = data_sel;
    assign bus.mi_cmd_valid = valid_sel & !(trk_full & is_read);
    assign bus.grant_sc     = grant;
    assign bus.pf_idle      = bus.mi_tx_active ? grant_q : bus.block_prefetch;

    assign push  = bus.mi_cmd_started & is_read;
    assign new_e = make_entry(grant, bus.sc_reply_wanted, bus.write_pc);

    reply_fifo #(
        .BITS  (ENTRY_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_reply_fifo (
        .clk        (clk),
        .reset      (reset),
        .add        (push),
        .remove     (bus.mi_rx_done),
        .new_entry  (new_e),
        .last_entry (last_e),
        .empty      (trk_empty),
        .full       (trk_full)
    );

    assign bus.full     = trk_full;
    assign bus.empty    = trk_empty;
    assign bus.rx_to_sc = !trk_empty & last_e[ENTRY_REPLY] & last_e[ENTRY_TO_SC];
    assign bus.rx_to_pf = !trk_empty & last_e[ENTRY_REPLY] & !last_e[ENTRY_TO_SC];

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: arbitration table plus tracker sequences.
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    localparam logic [3:0] RD = TX_HEADER_READ_16;
    localparam logic [3:0] WR = TX_HEADER_WRITE_16;

    tx_arbiter_if #(.IO_BITS(2), .CMD_BITS(TX_CMD_BITS)) bus ();

    tx_arbiter #(
        .IO_BITS         (2),
        .CMD_BITS        (TX_CMD_BITS),
        .MAX_OUTSTANDING (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pf_v;
        logic       sc_v;
        logic       res;
        logic       blk;
        logic       e_grant;
        logic       e_idle;
        logic       e_valid;
        logic [3:0] e_cmd;
        logic [1:0] e_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pf_cmd_valid    = 1'b0;
        bus.pf_cmd          = WR;
        bus.pf_data         = 2'b01;
        bus.sc_cmd_valid    = 1'b0;
        bus.sc_cmd          = WR;
        bus.sc_data         = 2'b10;
        bus.sc_reserve      = 1'b0;
        bus.sc_reply_wanted = 1'b0;
        bus.block_prefetch  = 1'b0;
        bus.write_pc        = 1'b0;
        bus.mi_cmd_started  = 1'b0;
        bus.mi_tx_active    = 1'b0;
        bus.mi_rx_done      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start_cycle();
        bus.mi_cmd_started = 1'b1;
        step();
        bus.mi_cmd_started = 1'b0;
    endtask

    task automatic pop_cycle();
        bus.mi_rx_done = 1'b1;
        step();
        bus.mi_rx_done = 1'b0;
    endtask

    logic exp_alt [3];

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, WR, 2'b01};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 1, RD, 2'b01};
        vecs[2] = '{0, 1, 0, 0, 1, 0, 1, WR, 2'b10};
        vecs[3] = '{1, 1, 0, 0, 1, 0, 1, WR, 2'b10};
        vecs[4] = '{1, 0, 1, 0, 1, 0, 0, WR, 2'b10};
        vecs[5] = '{1, 0, 0, 1, 1, 1, 0, WR, 2'b10};
        vecs[6] = '{0, 1, 0, 1, 1, 1, 1, WR, 2'b10};

        idle_inputs();
        reset = 1'b1;
        step();
        bus.sc_cmd_valid = 1'b1;
        step();
        bus.sc_cmd_valid = 1'b0;
        bus.mi_tx_active = 1'b1;
        #1;
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_rx_sc", bus.rx_to_sc, 0);
        check("rst_rx_pf", bus.rx_to_pf, 0);
        check("rst_grant_q", bus.grant_sc, 0);
        reset = 1'b0;
        bus.mi_tx_active = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            bus.pf_cmd_valid   = vecs[i].pf_v;
            bus.pf_cmd         = (i == 1) ? RD : WR;
            bus.sc_cmd_valid   = vecs[i].sc_v;
            bus.sc_reserve     = vecs[i].res;
            bus.block_prefetch = vecs[i].blk;
            #1;
            check($sformatf("v%0d_grant", i), bus.grant_sc, vecs[i].e_grant);
            check($sformatf("v%0d_idle", i), bus.pf_idle, vecs[i].e_idle);
            check($sformatf("v%0d_valid", i), bus.mi_cmd_valid, vecs[i].e_valid);
            check($sformatf("v%0d_cmd", i), bus.mi_cmd, vecs[i].e_cmd);
            check($sformatf("v%0d_data", i), bus.mi_data, vecs[i].e_data);
            step();
        end

        // prefetch read round trip
        do_reset();
        bus.pf_cmd_valid = 1'b1;
        bus.pf_cmd       = RD;
        #1;
        check("pf_rd_grant", bus.grant_sc, 0);
        start_cycle();
        bus.pf_cmd_valid = 1'b0;
        #1;
        check("pf_rd_empty", bus.empty, 0);
        check("pf_rd_rx_pf", bus.rx_to_pf, 1);
        check("pf_rd_rx_sc", bus.rx_to_sc, 0);
        pop_cycle();
        check("pf_rd_drain", bus.empty, 1);
        check("pf_rd_rx_off", bus.rx_to_pf, 0);

        // grant held during transfer
        do_reset();
        bus.sc_cmd_valid = 1'b1;
        step();
        bus.mi_tx_active = 1'b1;
        bus.sc_cmd_valid = 1'b0;
        bus.pf_cmd_valid = 1'b1;
        #1;
        check("hold_grant0", bus.grant_sc, 1);
        check("hold_idle0", bus.pf_idle, 1);
        step();
        step();
        check("hold_grant2", bus.grant_sc, 1);
        bus.mi_tx_active = 1'b0;
        #1;
        check("hold_release", bus.grant_sc, 0);
        check("hold_idle_rel", bus.pf_idle, 0);

        // contested arbitration across three starts
        do_reset();
`ifdef TX_ARB_ROUND_ROBIN_EN
        exp_alt = '{1'b1, 1'b0, 1'b1};
`else
        exp_alt = '{1'b1, 1'b1, 1'b1};
`endif
        bus.pf_cmd_valid = 1'b1;
        bus.sc_cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("alt%0d", i), bus.grant_sc, exp_alt[i]);
            start_cycle();
        end
        check("alt_no_push", bus.empty, 1);

        // tracker full blocks reads, not writes
        do_reset();
        bus.pf_cmd_valid = 1'b1;
        bus.pf_cmd       = RD;
        for (int i = 0; i < 3; i++) begin
            start_cycle();
        end
        check("full_flag", bus.full, 1);
        check("full_rd_blk", bus.mi_cmd_valid, 0);
        bus.pf_cmd = WR;
        #1;
        check("full_wr_ok", bus.mi_cmd_valid, 1);
        start_cycle();
        check("full_wr_nopush", bus.full, 1);
        pop_cycle();
        check("full_pop", bus.full, 0);

        // simultaneous push and pop keeps FIFO order
        do_reset();
        bus.sc_cmd_valid    = 1'b1;
        bus.sc_cmd          = RD;
        bus.sc_reply_wanted = 1'b1;
        start_cycle();
        bus.sc_cmd_valid    = 1'b0;
        bus.sc_reply_wanted = 1'b0;
        bus.pf_cmd_valid    = 1'b1;
        bus.pf_cmd          = RD;
        start_cycle();
        bus.pf_cmd_valid = 1'b0;
        #1;
        check("ord_head_sc", bus.rx_to_sc, 1);
        bus.sc_cmd_valid    = 1'b1;
        bus.sc_reply_wanted = 1'b1;
        bus.mi_rx_done      = 1'b1;
        start_cycle();
        bus.mi_rx_done      = 1'b0;
        bus.sc_cmd_valid    = 1'b0;
        bus.sc_reply_wanted = 1'b0;
        #1;
        check("ord_cnt_nfull", bus.full, 0);
        check("ord_head_pf", bus.rx_to_pf, 1);
        bus.pf_cmd_valid = 1'b1;
        start_cycle();
        bus.pf_cmd_valid = 1'b0;
        check("ord_cnt_full", bus.full, 1);
        pop_cycle();
        check("ord_third_sc", bus.rx_to_sc, 1);
        pop_cycle();
        check("ord_fourth_pf", bus.rx_to_pf, 1);
        pop_cycle();
        check("ord_empty", bus.empty, 1);

        // jump fetch reply goes to prefetcher; reset discards pending
        do_reset();
        bus.sc_cmd_valid    = 1'b1;
        bus.sc_cmd          = RD;
        bus.sc_reply_wanted = 1'b1;
        bus.write_pc        = 1'b1;
        start_cycle();
        bus.sc_reply_wanted = 1'b0;
        bus.write_pc        = 1'b0;
        start_cycle();
        check("jmp_rx_pf", bus.rx_to_pf, 1);
        check("jmp_rx_sc", bus.rx_to_sc, 0);
        pop_cycle();
        check("norep_empty", bus.empty, 0);
        check("norep_rx_pf", bus.rx_to_pf, 0);
        check("norep_rx_sc", bus.rx_to_sc, 0);
        reset = 1'b1;
        step();
        bus.sc_cmd_valid = 1'b0;
        bus.mi_tx_active = 1'b1;
        #1;
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_idle", bus.pf_idle, 0);
        reset = 1'b0;
        bus.mi_tx_active = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter IO_BITS, default 2, meaning memory-interface pin/data width per cycle.
REQ-002 SHALL have parameter CMD_BITS, default `TX_CMD_BITS, meaning TX command header width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 3, meaning max tracked reads awaiting reply.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pf_cmd_valid / pf_cmd / pf_data  in  1 / CMD_BITS / IO_BITS  prefetcher TX request, command, payload.
REQ-007 sc_cmd_valid / sc_cmd / sc_data  in  1 / CMD_BITS / IO_BITS  scheduler TX request, command, payload.
REQ-008 sc_reserve  in  1  scheduler holds TX channel (write follows read).
REQ-009 sc_reply_wanted  in  1  scheduler read expects routed reply.
REQ-010 block_prefetch  in  1  decoder forbids prefetch TX.
REQ-011 write_pc  in  1  current scheduler TX is a jump fetch; reply goes to prefetcher.
REQ-012 mi_cmd_valid / mi_cmd / mi_data  out  1 / CMD_BITS / IO_BITS  muxed request to memory interface.
REQ-013 mi_cmd_started / mi_tx_active / mi_rx_done  in  1 each  memory-interface status strobes.
REQ-014 grant_sc  out  1  TX channel owned by scheduler (else prefetcher).
REQ-015 pf_idle  out  1  prefetcher is locked out of TX.
REQ-016 rx_to_sc / rx_to_pf  out  1 each  current RX reply routed to scheduler / prefetcher.
REQ-017 full / empty  out  1 each  reply tracker full / empty.

Function
REQ-018 sc_want = sc_cmd_valid | sc_reserve | block_prefetch.
REQ-019 While !mi_tx_active: grant_sc = arbitration result (combinational), registered into grant_q each cycle.
REQ-020 While mi_tx_active: grant_sc = grant_q; no re-arbitration until transfer ends.
REQ-021 pf_idle = mi_tx_active ? grant_q : block_prefetch.
REQ-022 mi_cmd, mi_data = selected requester's fields; mi_cmd_valid = selected valid & !(full & mi_cmd==`TX_HEADER_READ_16).
REQ-023 Push tracker entry on mi_cmd_started & mi_cmd==`TX_HEADER_READ_16; writes never tracked.
REQ-024 Entry = {reply, to_sc}: prefetcher grant -> {1,0}; scheduler grant -> {sc_reply_wanted, !write_pc} when sc_reply_wanted, else {0,0}.
REQ-025 Pop oldest entry on mi_rx_done; rx_to_sc = !empty & reply & to_sc; rx_to_pf = !empty & reply & !to_sc.
REQ-026 Simultaneous push and pop: count unchanged, new entry written, oldest removed, same cycle.
REQ-027 Pop when empty: ignored; push when full: cannot occur (REQ-022), tracker SHALL not overwrite.
REQ-028 Pointers wrap modulo MAX_OUTSTANDING; count width $clog2(MAX_OUTSTANDING+1).

Reset
REQ-029 On reset: grant_q=0, tracker empty (empty=1, full=0), rx_to_sc=rx_to_pf=0, round-robin state=0.
REQ-030 Reset mid-transfer SHALL discard all outstanding entries; no output depends on pre-reset state next cycle.

Configuration
REQ-031 Macro TX_ARB_ROUND_ROBIN_EN defined: when both pf_cmd_valid and sc_cmd_valid with no sc_reserve/block_prefetch, the requester not granted last SHALL win; last-grant bit updates on mi_cmd_started.
REQ-032 Macro undefined: scheduler wins whenever sc_want; no last-grant state exists.

Structure
REQ-033 TX header encodings and TX_CMD_BITS SHALL come from the shared common header/package; entry field positions as localparams there.
REQ-034 Reply tracker SHALL be a sub-module reply_fifo (BITS, DEPTH params; add, remove, new_entry, last_entry, empty, full).

Verification
REQ-035 Idle, pf_cmd_valid=1 READ_16, start -> grant_sc=0, entry {1,0}, rx_done -> rx_to_pf=1 then empty=1.
REQ-036 Both valid, no macro -> grant_sc=1 every arbitration; with TX_ARB_ROUND_ROBIN_EN -> grants alternate sc,pf,sc.
REQ-037 grant sc, set mi_tx_active=1, drop sc_cmd_valid, raise pf_cmd_valid -> grant_sc stays 1 until mi_tx_active=0.
REQ-038 Three READ_16 starts with no rx_done -> full=1, mi_cmd_valid=0 for 4th read, write command still passes.
REQ-039 Push and rx_done same cycle with 2 outstanding -> count stays 2, order preserved (FIFO order of to_sc bits 1,0,1).
REQ-040 Scheduler read with write_pc=1 -> entry {1,0}, reply routed rx_to_pf=1; reset during pending reply -> empty=1 next cycle.
